imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder for the pipelined RISC-V CPU: the memory-side end of the fetch request/response interface. Accepts word fetch requests from the IF stage, returns instruction words after a fixed, parameterised latency through a bounded response queue with backpressure, and supports flush of all in-flight fetches on a branch redirect. A load port preloads program contents from the testbench or boot logic.

## Interface
- DEPTH_WORDS, 256: memory size in 32-bit words, power of two.
- LATENCY, 2: cycles from request acceptance to response entering the queue; must be 1 or greater.
- QDEPTH, 4: maximum outstanding requests, which is also the response queue depth; power of two.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address of the fetch.
- resp_valid  out  1  response word available.
- resp_ready  in  1  consumer takes the response this cycle.
- resp_data  out  32  instruction word.
- resp_addr  out  32  byte address the response belongs to.
- resp_err  out  1  the address was misaligned or out of range.
- flush  in  1  discard every in-flight and queued response.
- load_en  in  1  write load_data into memory.
- load_addr  in  32  byte address of the load write.
- load_data  in  32  word to write.

## Operation
- Memory contents are initialised to 0x00000013 (NOP) at time zero. Reset does not clear memory.
- **Accept:** a request is accepted when req_valid and req_ready are both high at a clock edge.
- **Address check:**
  - The word index is req_addr[log2(DEPTH_WORDS)+1:2].
  - resp_err = 1 if req_addr[1:0] is not 0, or if req_addr is at or above 4*DEPTH_WORDS.
  - On error, resp_data = 0x00000013.
- **Data capture:** the memory word is read at the acceptance edge. If load_en writes the same word in that same cycle, the response carries the old (pre-write) word.
- **Pipeline:** accepted requests travel through a LATENCY-stage shift pipeline. Each stage carries valid, addr, data and err. When a request leaves the last stage it is written into the FIFO response queue.
- **Outstanding counter:**
  - `outstanding` counts requests in the pipeline plus entries in the queue.
  - It increments on acceptance and decrements when a response is consumed (resp_valid and resp_ready both high).
  - Acceptance and consumption in the same cycle leave the count unchanged.
- **Backpressure:** req_ready = !rst && !flush && (outstanding < QDEPTH). The queue therefore never overflows.
- **Ordering:** responses are returned strictly in request order.
- **Output hold:** resp_valid = queue not empty. resp_data, resp_addr and resp_err show the queue head and stay stable while resp_valid && !resp_ready.
- **Flush:**
  - At the edge where flush = 1, all pipeline valids are cleared, the queue is emptied and outstanding becomes 0.
  - Nothing is accepted or consumed in that cycle.
  - resp_valid is 0 in the cycle after the flush edge.
- **Load port:**
  - When load_en = 1, load_data is written to word load_addr[log2(DEPTH_WORDS)+1:2].
  - The write is ignored if load_addr is misaligned or out of range.
  - Writes are independent of flush and of the request path.
- **Reset:** rst has priority over flush and over all other inputs.

## Timing
- **Reset values:** req_ready 0 while rst = 1, and 1 in the first cycle after rst deasserts. resp_valid 0, resp_data 0x00000013, resp_addr 0, resp_err 0. outstanding 0, pipeline empty.
- **Latency:** a request accepted at edge N raises resp_valid in the cycle after edge N+LATENCY, provided the queue ahead of it is empty. With back-to-back consumption this gives one response per cycle.
- **Full:** when outstanding = QDEPTH, req_ready is low. It rises in the cycle after a consumption edge.
- **Empty:** while resp_valid = 0, resp_ready is ignored.
- **Flush versus response:** a response leaving the pipeline on the flush edge is discarded.
- **Reset mid-operation:** an in-flight fetch is dropped without producing a response.

## Test plan
- **Reset then single fetch.** Hold rst for 3 cycles, then preload word 0 = 0x00500093 via load_en and request addr 0 with LATENCY = 2 → resp_valid is high two cycles after acceptance with resp_data 0x00500093, resp_addr 0, resp_err 0.
- **Streaming.** Request addresses 0, 4, 8 and 12 on consecutive cycles with resp_ready held at 1 → four in-order responses on consecutive cycles; req_ready never drops.
- **Backpressure.** Hold resp_ready = 0 and issue 5 requests → only 4 are accepted and req_ready goes low. Pulse resp_ready once → the head for address 0 is consumed and req_ready returns to 1 the next cycle.
- **Error cases.** Request addr 0x2 → resp_err 1 with data 0x00000013. Request addr 0x400 with DEPTH_WORDS = 256 → resp_err 1. Load to address 0x401 → memory is unchanged.
- **Flush.** With 3 requests outstanding (one queued, two in the pipeline), assert flush for one cycle → resp_valid is 0 afterwards and outstanding is 0. A new request to addr 8 returns only the addr 8 response.
- **Simultaneous load and read.** Word 3 holds 0x00000013. In one cycle, load 0xDEADBEEF to addr 12 and request addr 12 → the response returns 0x00000013. A second request to addr 12 returns 0xDEADBEEF.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch pipeline feeding a bounded
// in-order response queue, with branch-redirect flush and a preload write port.
module imem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int QDEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [31:0] resp_addr,
    output logic        resp_err,
    input  logic        flush,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int QW = $clog2(QDEPTH);
    localparam int OW = $clog2(QDEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Misaligned or beyond the last word of the memory.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

    logic [31:0] mem [DEPTH_WORDS] = '{default: NOP};

    logic [LATENCY-1:0] pipe_valid;
    logic [31:0]        pipe_addr [LATENCY];
    logic [31:0]        pipe_data [LATENCY];
    logic [LATENCY-1:0] pipe_err;

    logic [31:0] q_addr [QDEPTH];
    logic [31:0] q_data [QDEPTH];
    logic        q_err  [QDEPTH];
    logic [QW-1:0] wr_ptr;
    logic [QW-1:0] rd_ptr;
    logic [OW-1:0] q_count;
    logic [OW-1:0] outstanding;

    logic accept;
    logic pop;
    logic push;
    logic req_bad;

    assign req_ready  = !rst && !flush && (outstanding < OW'(QDEPTH));
    assign accept     = req_valid && req_ready;
    assign resp_valid = (q_count != '0);
    assign pop        = resp_valid && resp_ready;
    assign push       = pipe_valid[LATENCY-1];
    assign req_bad    = addr_bad(req_addr);

    // Empty queue presents the idle pattern rather than stale storage.
    assign resp_data = resp_valid ? q_data[rd_ptr] : NOP;
    assign resp_addr = resp_valid ? q_addr[rd_ptr] : 32'h0000_0000;
    assign resp_err  = resp_valid ? q_err[rd_ptr]  : 1'b0;

    // Preload write port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && load_en && !addr_bad(load_addr)) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    // Fetch pipeline; the read sees the pre-write word on a same-cycle load.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_addr[0]  <= req_addr;
            pipe_data[0]  <= req_bad ? NOP : mem[req_addr[AW+1:2]];
            pipe_err[0]   <= req_bad;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
                pipe_data[i]  <= pipe_data[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
        end
    end

    // Response queue storage.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            q_addr[wr_ptr] <= pipe_addr[LATENCY-1];
            q_data[wr_ptr] <= pipe_data[LATENCY-1];
            q_err[wr_ptr]  <= pipe_err[LATENCY-1];
        end
    end

    // Queue pointers and the outstanding count that throttles acceptance.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_count     <= '0;
            outstanding <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + QW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + QW'(1);
            end
            q_count     <= q_count + OW'(push) - OW'(pop);
            outstanding <= outstanding + OW'(accept) - OW'(pop);
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Randomised scoreboard bench for imem_responder: a word-array reference model
// predicts handshakes and responses; a negedge monitor compares the DUT.
module tb_imem_responder;
    localparam int DEPTH_WORDS = 256;
    localparam int LATENCY     = 2;
    localparam int QDEPTH      = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [31:0] resp_addr;
    logic        resp_err;
    logic        flush = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'h0;
    logic [31:0] load_data = 32'h0;

    imem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_addr(resp_addr), .resp_err(resp_err), .flush(flush),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          due;   // edge after which the response is visible
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mmem [DEPTH_WORDS];
    int          mout = 0;
    int          cyc  = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: plain word array, a list of expected responses, a count.
    always @(posedge clk) begin
        logic  do_pop;
        exp_t  e;
        do_pop = resp_ready && sb.size() > 0 && sb[0].due <= cyc;
        cyc++;
        if (rst) begin
            sb.delete();
            mout = 0;
        end else begin
            if (flush) begin
                sb.delete();
                mout = 0;
            end else begin
                if (do_pop) begin
                    void'(sb.pop_front());
                    mout--;
                end
                if (req_valid && (mout + (do_pop ? 1 : 0)) < QDEPTH) begin
                    e.addr = req_addr;
                    e.err  = (req_addr % 4 != 0) || (req_addr >= 4 * DEPTH_WORDS);
                    e.data = e.err ? NOP : mmem[req_addr / 4];
                    e.due  = cyc + LATENCY;
                    sb.push_back(e);
                    mout++;
                end
            end
            if (load_en && load_addr % 4 == 0 && load_addr < 4 * DEPTH_WORDS)
                mmem[load_addr / 4] = load_data;
        end
    end

    // Monitor: handshake signals every cycle, head of queue whenever valid.
    always @(negedge clk) begin
        logic exp_ready;
        logic exp_valid;
        exp_ready = !rst && !flush && mout < QDEPTH;
        exp_valid = sb.size() > 0 && sb[0].due <= cyc;
        check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
        check("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
        if (exp_valid && resp_valid) begin
            check("resp_data", resp_data, sb[0].data);
            check("resp_addr", resp_addr, sb[0].addr);
            check("resp_err", {31'b0, resp_err}, {31'b0, sb[0].err});
        end
    end

    task automatic drive(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                         input logic le, input logic [31:0] la, input logic [31:0] ld);
        req_valid = rv; req_addr = ra; resp_ready = rr; flush = fl;
        load_en = le; load_addr = la; load_data = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rr, input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mmem[i] = NOP;

        rst = 1'b1;
        idle(1'b0, 3);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_data", resp_data, NOP);
        check("rst_resp_addr", resp_addr, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'h0);
        rst = 1'b0;

        // Single fetch after preload
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0050_0093);
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1'b1, 4);

        // Streaming
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1'b1, 4);

        // Backpressure: five requests, four fit
        for (int i = 0; i < 5; i++) drive(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1'b0, 3);
        idle(1'b1, 1);
        idle(1'b0, 1);
        idle(1'b1, 6);

        // Error cases and a rejected load
        drive(1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h401, 32'hFFFF_FFFF);
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1'b1, 5);

        // Flush with one queued and two in the pipeline
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1'b1, 5);

        // Same-cycle load and read of word 3
        drive(1'b1, 32'd12, 1'b1, 1'b0, 1'b1, 32'd12, 32'hDEAD_BEEF);
        drive(1'b1, 32'd12, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1'b1, 5);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra;
            logic [31:0] la;
            ra = 32'($urandom_range(0, DEPTH_WORDS - 1) * 4);
            if ($urandom_range(0, 9) == 0) ra = $urandom_range(0, 5000);
            la = 32'($urandom_range(0, DEPTH_WORDS - 1) * 4);
            if ($urandom_range(0, 7) == 0) la = $urandom_range(0, 5000);
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) != 0, ra, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, la, $urandom);
        end
        rst = 1'b0;
        idle(1'b1, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
